tx_byte_fifo: RTL and testbench
===============================

// Module: tx_byte_fifo
// PURPOSE
//   Elastic byte buffer between the bf_top output (tx_data/tx_send/tx_busy) and the
//   avr_interface transmit port (tx_data/new_tx_data/tx_busy).
//   - Absorbs bursts of output bytes from the interpreter while the AVR UART link is
//     busy or blocked (avr_rx_busy).
//   - Drains bytes in order, one avr_interface handshake at a time.
//   - Instantiated in mojo_top between bt and avr.
// PARAMETERS
//   DEPTH_LOG2  4  log2 of storage depth; DEPTH = 2**DEPTH_LOG2 bytes (16)
//   HOLDOFF     2  cycles after each new_tx_data pulse during which tx_busy is ignored
//                  (covers avr_interface busy-assert lag); legal range 1..15
// PORTS
//   clk          in   1             system clock; all logic on posedge
//   rst_n        in   1             reset; synchronous, active-low
//   in_data      in   8             byte from bf_top
//   in_send      in   1             1-cycle write strobe from bf_top
//   in_busy      out  1             high when FIFO full; to bf_top tx_busy
//   tx_data      out  8             byte to avr_interface tx_data
//   new_tx_data  out  1             1-cycle send strobe to avr_interface
//   tx_busy      in   1             avr_interface tx_busy
//   count        out  DEPTH_LOG2+1  bytes currently stored (0..DEPTH)
//   overflow     out  1             sticky: a write was dropped because FIFO full
// BEHAVIOUR
//   Reset (rst_n low at posedge):
//   - rd_ptr = wr_ptr = 0, count = 0, state = IDLE, in_busy = 0.
//   - new_tx_data = 0, tx_data = 8'h00, overflow = 0.
//   - Storage contents are don't-care.
//   - Reset mid-drain abandons any pending byte; no strobe is issued in the reset cycle.
//   Storage:
//   - DEPTH-entry circular RAM; pointers are DEPTH_LOG2 bits and wrap DEPTH-1 -> 0.
//   - count is tracked separately; full = (count == DEPTH), empty = (count == 0).
//   - in_busy = full, registered from the post-update count.
//   Write:
//   - in_send && !full: mem[wr_ptr] <= in_data; wr_ptr++.
//   - in_send && full: byte dropped; overflow <= 1 and stays 1 until reset.
//   - Full check uses count before this cycle's pop, so a simultaneous pop does not
//     admit a write while full.
//   Pop:
//   - Occurs in the IDLE->SEND transition: tx_data <= mem[rd_ptr]; rd_ptr++.
//   - Simultaneous push and pop leaves count unchanged; otherwise count +1 / -1.
//   - No bypass: a byte written into an empty FIFO is popped on a later cycle.
//   FSM (states IDLE, SEND, HOLD):
//   - IDLE: if !empty && !tx_busy -> pop, go to SEND.
//   - SEND: new_tx_data = 1 for exactly this cycle (registered output);
//     hold counter <= HOLDOFF-1; go to HOLD.
//   - HOLD: new_tx_data = 0; tx_busy ignored; decrement hold counter; go to IDLE when
//     it reaches 0.
//   - tx_data stays stable from SEND until the next SEND.
//   Latency and throughput:
//   - In empty FIFO with tx_busy low: in_send sampled at edge N -> new_tx_data high in
//     cycle N+2.
//   - Minimum strobe spacing is HOLDOFF+2 cycles.
//   - Bytes leave in exact write order; none duplicated; none lost except counted
//     overflow drops.
//   tx_busy rising in IDLE: no pop until it falls; FIFO keeps accepting writes.
// TESTING
//   1. Reset then idle:
//      - in_busy=0, new_tx_data=0, count=0, overflow=0 for 20 cycles.
//   2. Single byte, tx_busy=0:
//      - in_send with 8'h41 at edge N -> new_tx_data=1 and tx_data=8'h41 in cycle N+2
//        only; count returns to 0.
//   3. tx_busy=1, write 16 bytes 0x00..0x0F:
//      - count=16, in_busy=1.
//      - 17th write 0xFF -> dropped, overflow=1.
//      - Release tx_busy with the model busy for 10 cycles per strobe -> exactly
//        0x00..0x0F emitted in order.
//   4. Wrap-around:
//      - Push/pop 40 bytes 0x00..0x27 with random tx_busy -> all 40 in order,
//        count never >16.
//   5. Simultaneous push and pop with count=5 -> count stays 5; ordering preserved.
//   6. Reset mid-operation:
//      - rst_n low for 1 cycle while in HOLD with count=7 -> count=0, new_tx_data=0,
//        overflow=0.
//      - Next written byte 0x55 is the next byte emitted.

Source files
------------

// File: rtl/tx_byte_fifo.sv
// Elastic byte FIFO between the interpreter output and the AVR UART transmit port.
// Bytes drain in write order, one new_tx_data strobe per byte, with a busy holdoff after each strobe.
module tx_byte_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int HOLDOFF    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_send,
    output logic                  in_busy,
    output logic [7:0]            tx_data,
    output logic                  new_tx_data,
    input  logic                  tx_busy,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [1:0]            state_dbg
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [3:0]            HOLD_INIT  = 4'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [3:0]            hold_cnt;
    logic [3:0]            hold_next;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_next;
    logic [7:0]            mem [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;

    // Full is judged on the pre-pop count, so a pop never makes room for a same-cycle write.
    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign push      = in_send && !full;
    assign pop       = (state == IDLE) && !empty && !tx_busy;
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                hold_next  = HOLD_INIT;
                state_next = HOLD;
            end
            HOLD: begin
                // tx_busy is deliberately not looked at here: the link raises it late.
                if (hold_cnt == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    hold_next = hold_cnt - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= 4'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            in_busy     <= 1'b0;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_next;
            count       <= count_next;
            in_busy     <= (count_next == FULL_COUNT);
            new_tx_data <= (state_next == SEND);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
            if (in_send && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset; contents behind the pointers are never observed.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_tx_byte_fifo.sv
// Randomised bench for tx_byte_fifo: a byte queue plus a simple busy-link model
// predict every strobe, byte, count and flag cycle by cycle.
module tb_tx_byte_fifo;

    localparam int DEPTH   = 16;
    localparam int HOLDOFF = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_send = 1'b0;
    logic       in_busy;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy = 1'b0;
    logic [4:0] count;
    logic       overflow;
    logic [1:0] state_dbg;

    tx_byte_fifo #(.DEPTH_LOG2(4), .HOLDOFF(HOLDOFF)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_send(in_send),
        .in_busy(in_busy), .tx_data(tx_data), .new_tx_data(new_tx_data),
        .tx_busy(tx_busy), .count(count), .overflow(overflow), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    logic [7:0] last_tx = 8'h00;
    int         cyc = 0;
    int         last_strobe_cyc = -1;
    int         emitted = 0;
    int         busy_cnt = 0;
    int         busy_len = 10;
    logic       force_busy = 1'b0;
    logic       strobe_seen = 1'b0;

    // One clock: drive inputs, advance the model at the edge, then check outputs 1ns later.
    task automatic step(input logic send, input logic [7:0] d, input logic rst_req);
        int pre;
        logic [7:0] got;
        pre = exp_q.size();
        rst_n   = !rst_req;
        in_send = send;
        in_data = d;
        tx_busy = force_busy || (busy_cnt != 0);
        @(posedge clk);
        cyc++;
        if (rst_req) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            last_tx = 8'h00;
            last_strobe_cyc = -1;
            pre = 0;
        end else if (send) begin
            if (pre < DEPTH) exp_q.push_back(d);
            else exp_ovf = 1'b1;
        end
        #1;
        strobe_seen = (new_tx_data === 1'b1);
        if (busy_cnt > 0) busy_cnt--;
        if (new_tx_data === 1'b1) begin
            total++;
            if (pre == 0) begin
                bad++;
                $display("FAIL strobe_from_empty: got new_tx_data=1 want 0 (cycle %0d)", cyc);
            end else begin
                got = exp_q.pop_front();
                emitted++;
                total++;
                if (tx_data !== got) begin
                    bad++;
                    $display("FAIL tx_byte: got %02h want %02h (cycle %0d)", tx_data, got, cyc);
                end
                last_tx = got;
            end
            if (last_strobe_cyc >= 0) begin
                total++;
                if (cyc - last_strobe_cyc < HOLDOFF + 2) begin
                    bad++;
                    $display("FAIL strobe_spacing: got %0d want >=%0d", cyc - last_strobe_cyc, HOLDOFF + 2);
                end
            end
            last_strobe_cyc = cyc;
            busy_cnt = busy_len;
        end else begin
            total++;
            if (tx_data !== last_tx) begin
                bad++;
                $display("FAIL tx_data_stable: got %02h want %02h (cycle %0d)", tx_data, last_tx, cyc);
            end
        end
        total++;
        if (count !== 5'(exp_q.size())) begin
            bad++;
            $display("FAIL count: got %0d want %0d (cycle %0d)", count, exp_q.size(), cyc);
        end
        total++;
        if (in_busy !== (exp_q.size() == DEPTH)) begin
            bad++;
            $display("FAIL in_busy: got %b want %b (cycle %0d)", in_busy, exp_q.size() == DEPTH, cyc);
        end
        total++;
        if (overflow !== exp_ovf) begin
            bad++;
            $display("FAIL overflow: got %b want %b (cycle %0d)", overflow, exp_ovf, cyc);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_cnt != 0) && n < budget) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d bytes left want 0", exp_q.size());
        end
        repeat (HOLDOFF + 2) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h99, 1'b1);
        total++;
        if (tx_data !== 8'h00 || new_tx_data !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got tx_data=%02h new=%b want 00 0", tx_data, new_tx_data);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'h00, 1'b0);
            total++;
            if (in_busy !== 1'b0 || new_tx_data !== 1'b0 || count !== 5'd0 || overflow !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle: got busy=%b new=%b count=%0d ovf=%b want 0 0 0 0",
                         in_busy, new_tx_data, count, overflow);
            end
        end
    endtask

    task automatic test_single();
        busy_len = 10;
        step(1'b1, 8'h41, 1'b0);
        total++;
        if (strobe_seen !== 1'b0) begin
            bad++;
            $display("FAIL single_no_bypass: got strobe=1 want 0");
        end
        step(1'b0, 8'h00, 1'b0);
        total++;
        if (strobe_seen !== 1'b1 || tx_data !== 8'h41) begin
            bad++;
            $display("FAIL single_latency: got strobe=%b data=%02h want 1 41", strobe_seen, tx_data);
        end
        step(1'b0, 8'h00, 1'b0);
        total++;
        if (new_tx_data !== 1'b0) begin
            bad++;
            $display("FAIL single_one_cycle: got new_tx_data=%b want 0", new_tx_data);
        end
        drain(200);
        total++;
        if (count !== 5'd0) begin
            bad++;
            $display("FAIL single_count: got %0d want 0", count);
        end
    endtask

    task automatic test_fill_overflow();
        int e0;
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        total++;
        if (count !== 5'd16 || in_busy !== 1'b1) begin
            bad++;
            $display("FAIL fill: got count=%0d busy=%b want 16 1", count, in_busy);
        end
        step(1'b1, 8'hFF, 1'b0);
        total++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            bad++;
            $display("FAIL overflow_drop: got ovf=%b count=%0d want 1 16", overflow, count);
        end
        force_busy = 1'b0;
        busy_len = 10;
        e0 = emitted;
        drain(2000);
        total++;
        if (emitted - e0 != 16) begin
            bad++;
            $display("FAIL fill_emitted: got %0d want 16", emitted - e0);
        end
    endtask

    task automatic test_wraparound();
        int sent;
        int n;
        int e0;
        sent = 0;
        n = 0;
        e0 = emitted;
        while ((sent < 40 || exp_q.size() != 0) && n < 3000) begin
            force_busy = ($urandom_range(0, 3) == 0);
            busy_len = $urandom_range(0, 12);
            if (sent < 40 && exp_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                step(1'b1, 8'(sent), 1'b0);
                sent++;
            end else begin
                step(1'b0, 8'h00, 1'b0);
            end
            total++;
            if (count > 5'd16) begin
                bad++;
                $display("FAIL wrap_count_bound: got %0d want <=16", count);
            end
            n++;
        end
        force_busy = 1'b0;
        drain(500);
        total++;
        if (emitted - e0 != 40) begin
            bad++;
            $display("FAIL wrap_emitted: got %0d want 40", emitted - e0);
        end
    endtask

    task automatic test_simultaneous();
        force_busy = 1'b1;
        busy_len = 10;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
        force_busy = 1'b0;
        step(1'b1, 8'hA5, 1'b0);
        total++;
        if (strobe_seen !== 1'b1 || count !== 5'd5) begin
            bad++;
            $display("FAIL push_pop: got strobe=%b count=%0d want 1 5", strobe_seen, count);
        end
        drain(500);
    endtask

    task automatic test_reset_mid();
        int n;
        force_busy = 1'b1;
        busy_len = 10;
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        force_busy = 1'b0;
        n = 0;
        strobe_seen = 1'b0;
        while (!strobe_seen && n < 10) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        total++;
        if (!strobe_seen) begin
            bad++;
            $display("FAIL mid_strobe_timeout: got no strobe want strobe");
        end
        step(1'b0, 8'h00, 1'b0);
        total++;
        if (count !== 5'd7) begin
            bad++;
            $display("FAIL mid_count: got %0d want 7", count);
        end
        step(1'b0, 8'h00, 1'b1);
        total++;
        if (count !== 5'd0 || new_tx_data !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got count=%0d new=%b ovf=%b want 0 0 0", count, new_tx_data, overflow);
        end
        step(1'b1, 8'h55, 1'b0);
        drain(500);
        total++;
        if (last_tx !== 8'h55 || tx_data !== 8'h55) begin
            bad++;
            $display("FAIL mid_next_byte: got %02h want 55", tx_data);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_wraparound();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
